lampfpu_sqrt_issue: RTL and testbench

Request-side sequencer for the fractional square-root core.
- Accepts a 16-bit lamp float operand (1 sign, 8 exponent, 7 fraction, bias 127) with a sqrt or inverse-sqrt command.
- Handles special operands locally.
- Otherwise derives the core significand, pulses the core's command inputs and waits for the core's valid.
- Renormalises the core's fixed-point result into a lamp float and returns it with a single-cycle valid.

---
 rtl/lampfpu_sqrt_issue_pkg.sv | 60 ++++++
 rtl/lampfpu_sqrt_issue_if.sv | 34 +++
 rtl/lampfpu_sqrt_norm.sv | 56 +++++
 rtl/lampfpu_sqrt_issue.sv | 167 ++++++++++++++++
 tb/tb_lampfpu_sqrt_issue.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lampfpu_sqrt_issue_pkg.sv
// Shared definitions for the lamp-float square-root request sequencer.
//   - lamp float geometry (1 sign, 8 exponent, 7 fraction, bias 127)
//   - canonical special results (quiet NaN, +inf, -inf)
//   - sequencer FSM state encoding
//   - classify(): detects operands answered without the core and forms their result
package lampfpu_sqrt_issue_pkg;

    localparam int LAMP_FLOAT_DW   = 16;
    localparam int LAMP_FLOAT_E_DW = 8;
    localparam int LAMP_FLOAT_F_DW = 7;
    localparam int LAMP_FLOAT_BIAS = 127;

    // Signed width large enough for K (range -124..128) and the biased result exponent.
    localparam int K_W = 10;

    localparam logic [LAMP_FLOAT_DW-1:0] QNAN = 16'h7FC0;
    localparam logic [LAMP_FLOAT_DW-1:0] PINF = 16'h7F80;
    localparam logic [LAMP_FLOAT_DW-1:0] NINF = 16'hFF80;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic                     special;
        logic [LAMP_FLOAT_DW-1:0] res;
    } special_t;

    // Exponent 0 is flushed to zero whatever the fraction holds. The order of the
    // tests matters: NaN first, then zeros (so -0 is not caught as negative), then
    // any remaining negative value, then +inf.
    function automatic special_t classify(input logic [LAMP_FLOAT_DW-1:0] op,
                                         input logic                     inv);
        logic                       sgn;
        logic [LAMP_FLOAT_E_DW-1:0] e;
        logic [LAMP_FLOAT_F_DW-1:0] f;
        special_t                   r;
        sgn       = op[LAMP_FLOAT_DW-1];
        e         = op[LAMP_FLOAT_DW-2 -: LAMP_FLOAT_E_DW];
        f         = op[LAMP_FLOAT_F_DW-1:0];
        r.special = 1'b1;
        r.res     = QNAN;
        if (e == '1 && f != '0) begin
            r.res = QNAN;
        end else if (e == '0) begin
            r.res = inv ? (sgn ? NINF : PINF) : {sgn, 15'b0};
        end else if (sgn) begin
            r.res = QNAN;
        end else if (e == '1) begin
            r.res = inv ? '0 : PINF;
        end else begin
            r.special = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/lampfpu_sqrt_issue_if.sv
// Request/response and core-command bundle of the square-root sequencer.
//   slave  : the sequencer (takes requests and core results, drives results and core commands)
//   master : the requester plus the core model / core wrapper around it
// Request side : doSqrt_i, doInvSqrt_i, op_i -> ready_o, result_o, valid_o, err_o
// Core side    : core_doSqrt_o, core_doInvSqrt_o, core_s_o -> core_result_i, core_valid_i
interface lampfpu_sqrt_issue_if;
    import lampfpu_sqrt_issue_pkg::*;

    logic                     doSqrt_i;
    logic                     doInvSqrt_i;
    logic [LAMP_FLOAT_DW-1:0] op_i;
    logic                     ready_o;
    logic [LAMP_FLOAT_DW-1:0] result_o;
    logic                     valid_o;
    logic                     err_o;
    logic                     core_doSqrt_o;
    logic                     core_doInvSqrt_o;
    logic [7:0]               core_s_o;
    logic [15:0]              core_result_i;
    logic                     core_valid_i;

    modport master (
        output doSqrt_i, doInvSqrt_i, op_i, core_result_i, core_valid_i,
        input  ready_o, result_o, valid_o, err_o,
               core_doSqrt_o, core_doInvSqrt_o, core_s_o
    );

    modport slave (
        input  doSqrt_i, doInvSqrt_i, op_i, core_result_i, core_valid_i,
        output ready_o, result_o, valid_o, err_o,
               core_doSqrt_o, core_doInvSqrt_o, core_s_o
    );

endinterface

// File: rtl/lampfpu_sqrt_norm.sv
// Combinational renormalisation of the core's Q2.14 result into a lamp float.
//   core_res_i : core result, unsigned Q2.14 (1.0 sits at bit CORE_RES_W-2)
//   k_i        : even exponent offset K chosen when the significand was mapped
//   inv_i      : 1 for inverse square root (exponent contribution is -K/2)
//   result_o   : positive lamp float, or QNAN if no leading one in the top three bits
module lampfpu_sqrt_norm
    import lampfpu_sqrt_issue_pkg::*;
#(
    parameter int CORE_RES_W = 16
) (
    input  logic [CORE_RES_W-1:0]    core_res_i,
    input  logic signed [K_W-1:0]    k_i,
    input  logic                     inv_i,
    output logic [LAMP_FLOAT_DW-1:0] result_o
);

    localparam int ONE_POS = CORE_RES_W - 2;

    logic                       found;
    logic signed [K_W-1:0]      p_off;
    logic signed [K_W-1:0]      half_k;
    logic signed [K_W-1:0]      exp_b;
    logic [LAMP_FLOAT_F_DW-1:0] frac;
    logic                       unused_bits;

    always_comb begin
        found = 1'b1;
        p_off = '0;
        frac  = '0;
        // p - 14 is +1, 0 or -1; fraction is the 7 bits right below the leading one.
        if (core_res_i[ONE_POS+1]) begin
            p_off = K_W'(1);
            frac  = core_res_i[ONE_POS -: LAMP_FLOAT_F_DW];
        end else if (core_res_i[ONE_POS]) begin
            p_off = '0;
            frac  = core_res_i[ONE_POS-1 -: LAMP_FLOAT_F_DW];
        end else if (core_res_i[ONE_POS-1]) begin
            p_off = '1;
            frac  = core_res_i[ONE_POS-2 -: LAMP_FLOAT_F_DW];
        end else begin
            found = 1'b0;
        end

        // K is always even, so the arithmetic shift is an exact halving.
        half_k = k_i >>> 1;
        exp_b  = (inv_i ? -half_k : half_k) + p_off + K_W'(LAMP_FLOAT_BIAS);

        result_o = found ? {1'b0, exp_b[LAMP_FLOAT_E_DW-1:0], frac} : QNAN;
    end

    // Exponent stays within 1..254 for normal inputs; the low result bits are below
    // the truncation point.
    assign unused_bits = ^{exp_b[K_W-1:LAMP_FLOAT_E_DW],
                           core_res_i[ONE_POS-LAMP_FLOAT_F_DW-2:0]};

endmodule

// File: rtl/lampfpu_sqrt_issue.sv
// Request-side sequencer for the fractional square-root core.
//   clk, rst : clock (rising edge) and synchronous active-low reset
//   bus      : slave side of lampfpu_sqrt_issue_if
//              request  doSqrt_i / doInvSqrt_i / op_i, accepted while ready_o=1
//              response result_o with one-cycle valid_o (err_o on watchdog abort)
//              core     one-cycle core_doSqrt_o / core_doInvSqrt_o with core_s_o,
//                       completion via core_valid_i / core_result_i
// Special operands are answered directly; normal operands are mapped to a Q0.8
// significand in [0.25,1) plus an even exponent offset K, sent to the core, and
// the core's Q2.14 answer is renormalised on the cycle core_valid_i arrives.
module lampfpu_sqrt_issue
    import lampfpu_sqrt_issue_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CORE_RES_W     = 2 * (1 + LAMP_FLOAT_F_DW)
) (
    input logic                 clk,
    input logic                 rst,
    lampfpu_sqrt_issue_if.slave bus
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t                   state_q, state_d;
    logic                     ready_q, ready_d;
    logic                     valid_q, valid_d;
    logic                     err_q, err_d;
    logic [LAMP_FLOAT_DW-1:0] result_q, result_d;
    logic                     core_sqrt_q, core_sqrt_d;
    logic                     core_inv_q, core_inv_d;
    logic [7:0]               core_s_q, core_s_d;
    logic signed [K_W-1:0]    k_q, k_d;
    logic                     inv_q, inv_d;
    logic [WD_W-1:0]          wdog_q, wdog_d;

    special_t                 spec;
    logic [7:0]               s_new;
    logic signed [K_W-1:0]    k_new;
    logic [LAMP_FLOAT_DW-1:0] norm_res;

    lampfpu_sqrt_norm #(
        .CORE_RES_W (CORE_RES_W)
    ) u_norm (
        .core_res_i (bus.core_result_i),
        .k_i        (k_q),
        .inv_i      (inv_q),
        .result_o   (norm_res)
    );

    // Significand mapping: exp even means E = exp-127 is odd, so s = 1.f/2 and
    // K = E+1 = exp-126; otherwise s = 1.f/4 (dropping f[0]) and K = E+2 = exp-125.
    always_comb begin
        spec = classify(bus.op_i, ~bus.doSqrt_i);
        if (bus.op_i[LAMP_FLOAT_F_DW] == 1'b0) begin
            s_new = {1'b1, bus.op_i[LAMP_FLOAT_F_DW-1:0]};
            k_new = $signed({2'b00, bus.op_i[14:7]}) - K_W'(126);
        end else begin
            s_new = {2'b01, bus.op_i[LAMP_FLOAT_F_DW-1:1]};
            k_new = $signed({2'b00, bus.op_i[14:7]}) - K_W'(125);
        end
    end

    always_comb begin
        state_d     = state_q;
        ready_d     = ready_q;
        valid_d     = valid_q;
        err_d       = err_q;
        result_d    = result_q;
        core_sqrt_d = core_sqrt_q;
        core_inv_d  = core_inv_q;
        core_s_d    = core_s_q;
        k_d         = k_q;
        inv_d       = inv_q;
        wdog_d      = wdog_q;

        unique case (state_q)
            IDLE: begin
                if (bus.doSqrt_i | bus.doInvSqrt_i) begin
                    ready_d = 1'b0;
                    // doSqrt_i takes priority when both are requested.
                    inv_d   = ~bus.doSqrt_i;
                    if (spec.special) begin
                        result_d = spec.res;
                        err_d    = 1'b0;
                        valid_d  = 1'b1;
                        state_d  = DONE;
                    end else begin
                        core_s_d    = s_new;
                        k_d         = k_new;
                        core_sqrt_d = bus.doSqrt_i;
                        core_inv_d  = ~bus.doSqrt_i;
                        state_d     = ISSUE;
                    end
                end
            end
            ISSUE: begin
                core_sqrt_d = 1'b0;
                core_inv_d  = 1'b0;
                wdog_d      = '0;
                state_d     = WAIT;
            end
            WAIT: begin
                // A core answer on the last watchdog cycle still wins over the abort.
                if (bus.core_valid_i) begin
                    result_d = norm_res;
                    err_d    = 1'b0;
                    valid_d  = 1'b1;
                    state_d  = DONE;
                end else if (wdog_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    result_d = QNAN;
                    err_d    = 1'b1;
                    valid_d  = 1'b1;
                    state_d  = DONE;
                end else begin
                    wdog_d = wdog_q + WD_W'(1);
                end
            end
            DONE: begin
                valid_d = 1'b0;
                err_d   = 1'b0;
                ready_d = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            ready_q     <= 1'b1;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            result_q    <= '0;
            core_sqrt_q <= 1'b0;
            core_inv_q  <= 1'b0;
            core_s_q    <= '0;
            k_q         <= '0;
            inv_q       <= 1'b0;
            wdog_q      <= '0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
            result_q    <= result_d;
            core_sqrt_q <= core_sqrt_d;
            core_inv_q  <= core_inv_d;
            core_s_q    <= core_s_d;
            k_q         <= k_d;
            inv_q       <= inv_d;
            wdog_q      <= wdog_d;
        end
    end

    assign bus.ready_o          = ready_q;
    assign bus.valid_o          = valid_q;
    assign bus.err_o            = err_q;
    assign bus.result_o         = result_q;
    assign bus.core_doSqrt_o    = core_sqrt_q;
    assign bus.core_doInvSqrt_o = core_inv_q;
    assign bus.core_s_o         = core_s_q;

endmodule

// File: tb/tb_lampfpu_sqrt_issue.sv
// Self-checking bench for lampfpu_sqrt_issue: table vectors, hand-written
// timeout / reset / busy sequences, and randomized requests against a
// value-level reference model.
module tb_lampfpu_sqrt_issue;

    localparam int          TO   = 64;
    localparam logic [15:0] QNAN = 16'h7FC0;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lampfpu_sqrt_issue_if bus();

    lampfpu_sqrt_issue #(
        .TIMEOUT_CYCLES (TO),
        .CORE_RES_W     (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model (value level) ----------------
    // Returns the special-case result, or -1 when the operand goes to the core.
    function automatic int ref_special(input logic [15:0] op, input bit inv);
        int e = int'(op[14:7]);
        int f = int'(op[6:0]);
        bit s = op[15];
        if (e == 255 && f != 0) return int'(QNAN);
        if (e == 0) begin
            if (inv) return s ? 32'hFF80 : 32'h7F80;
            return s ? 32'h8000 : 32'h0000;
        end
        if (s) return int'(QNAN);
        if (e == 255) return inv ? 0 : 32'h7F80;
        return -1;
    endfunction

    // Significand as a Q0.8 integer (1.f scaled by 128 is m; s = m/256 or m/512).
    function automatic void ref_sig(input logic [15:0] op, output logic [7:0] s, output int k);
        int e = int'(op[14:7]) - 127;
        int m = 128 + int'(op[6:0]);
        if (e % 2 != 0) begin
            s = 8'(m);
            k = e + 1;
        end else begin
            s = 8'(m / 2);
            k = e + 2;
        end
    endfunction

    function automatic logic [15:0] ref_norm(input logic [15:0] cr, input int k, input bit inv);
        int p;
        int ex;
        int frac;
        if (cr >= 16'h8000)      p = 15;
        else if (cr >= 16'h4000) p = 14;
        else if (cr >= 16'h2000) p = 13;
        else return QNAN;
        ex   = (inv ? -(k / 2) : (k / 2)) + (p - 14) + 127;
        frac = (int'(cr) >> (p - 7)) % 128;
        return 16'((ex << 7) | frac);
    endfunction

    // ---------------- one request, acting as the core ----------------
    task automatic run_txn(input string nm, input bit ds, input bit di,
                           input logic [15:0] op, input logic [15:0] cr, input int dly,
                           input bit special, input logic [7:0] exp_s,
                           input logic [15:0] exp_res);
        @(negedge clk);
        check({nm, "/ready_before"}, bus.ready_o, 1);
        bus.doSqrt_i    = ds;
        bus.doInvSqrt_i = di;
        bus.op_i        = op;
        @(negedge clk);                         // cycle T+1
        bus.doSqrt_i    = 1'b0;
        bus.doInvSqrt_i = 1'b0;
        bus.op_i        = 16'($urandom);
        check({nm, "/ready_busy"}, bus.ready_o, 0);
        if (special) begin
            check({nm, "/valid"}, bus.valid_o, 1);
            check({nm, "/result"}, bus.result_o, exp_res);
            check({nm, "/err"}, bus.err_o, 0);
            check({nm, "/no_core_cmd"}, {bus.core_doSqrt_o, bus.core_doInvSqrt_o}, 2'b00);
        end else begin
            check({nm, "/valid_early"}, bus.valid_o, 0);
            check({nm, "/core_cmd"}, {bus.core_doSqrt_o, bus.core_doInvSqrt_o}, {ds, ~ds});
            check({nm, "/core_s"}, bus.core_s_o, exp_s);
            @(negedge clk);                     // cycle T+2, waiting
            check({nm, "/cmd_one_cycle"}, {bus.core_doSqrt_o, bus.core_doInvSqrt_o}, 2'b00);
            for (int i = 0; i < dly; i++) begin
                check({nm, "/wait_no_valid"}, bus.valid_o, 0);
                @(negedge clk);
            end
            check({nm, "/core_s_hold"}, bus.core_s_o, exp_s);
            bus.core_valid_i  = 1'b1;
            bus.core_result_i = cr;
            @(negedge clk);                     // cycle W+1
            bus.core_valid_i  = 1'b0;
            bus.core_result_i = 16'($urandom);
            check({nm, "/valid"}, bus.valid_o, 1);
            check({nm, "/result"}, bus.result_o, exp_res);
            check({nm, "/err"}, bus.err_o, 0);
        end
        @(negedge clk);
        check({nm, "/valid_one_cycle"}, bus.valid_o, 0);
        check({nm, "/ready_after"}, bus.ready_o, 1);
    endtask

    typedef struct {
        string       name;
        bit          ds;
        bit          di;
        logic [15:0] op;
        logic [15:0] cr;
        bit          special;
        logic [7:0]  s;
        logic [15:0] res;
    } vec_t;

    vec_t tbl[$];

    initial begin
        logic [15:0] op, cr, res;
        logic [7:0]  s;
        bit          ds, di;
        int          k, sp, early, stray;

        rst               = 1'b0;
        bus.doSqrt_i      = 1'b0;
        bus.doInvSqrt_i   = 1'b0;
        bus.op_i          = '0;
        bus.core_valid_i  = 1'b0;
        bus.core_result_i = '0;

        tbl.push_back('{"sqrt_4",      1, 0, 16'h4080, 16'h2000, 0, 8'h40, 16'h4000});
        tbl.push_back('{"inv_4",       0, 1, 16'h4080, 16'h8000, 0, 8'h40, 16'h3F00});
        tbl.push_back('{"sqrt_2",      1, 0, 16'h4000, 16'h2D41, 0, 8'h80, 16'h3FB5});
        tbl.push_back('{"inv_2",       0, 1, 16'h4000, 16'h5A82, 0, 8'h80, 16'h3F35});
        tbl.push_back('{"sqrt_half",   1, 0, 16'h3F00, 16'h2D41, 0, 8'h80, 16'h3F35});
        tbl.push_back('{"inv_quarter", 0, 1, 16'h3E80, 16'h8000, 0, 8'h40, 16'h4000});
        tbl.push_back('{"sqrt_p14",    1, 0, 16'h4080, 16'h4000, 0, 8'h40, 16'h4080});
        tbl.push_back('{"both_high",   1, 1, 16'h4080, 16'h2000, 0, 8'h40, 16'h4000});
        tbl.push_back('{"no_lead_one", 0, 1, 16'h4080, 16'h1FFF, 0, 8'h40, 16'h7FC0});
        tbl.push_back('{"sqrt_neg",    1, 0, 16'hBF80, 16'h0000, 1, 8'h00, 16'h7FC0});
        tbl.push_back('{"inv_pzero",   0, 1, 16'h0000, 16'h0000, 1, 8'h00, 16'h7F80});
        tbl.push_back('{"sqrt_nzero",  1, 0, 16'h8000, 16'h0000, 1, 8'h00, 16'h8000});
        tbl.push_back('{"inv_nzero",   0, 1, 16'h8000, 16'h0000, 1, 8'h00, 16'hFF80});
        tbl.push_back('{"sqrt_pinf",   1, 0, 16'h7F80, 16'h0000, 1, 8'h00, 16'h7F80});
        tbl.push_back('{"inv_pinf",    0, 1, 16'h7F80, 16'h0000, 1, 8'h00, 16'h0000});
        tbl.push_back('{"sqrt_nan",    1, 0, 16'h7FC1, 16'h0000, 1, 8'h00, 16'h7FC0});
        tbl.push_back('{"sqrt_denorm", 1, 0, 16'h0055, 16'h0000, 1, 8'h00, 16'h0000});
        tbl.push_back('{"inv_ninf",    0, 1, 16'hFF80, 16'h0000, 1, 8'h00, 16'h7FC0});

        // Reset state
        repeat (3) @(negedge clk);
        check("rst/ready", bus.ready_o, 1);
        check("rst/valid", bus.valid_o, 0);
        check("rst/err", bus.err_o, 0);
        check("rst/result", bus.result_o, 0);
        check("rst/core_cmd", {bus.core_doSqrt_o, bus.core_doInvSqrt_o}, 2'b00);
        check("rst/core_s", bus.core_s_o, 0);
        rst = 1'b1;

        // Table vectors
        foreach (tbl[i])
            run_txn(tbl[i].name, tbl[i].ds, tbl[i].di, tbl[i].op, tbl[i].cr,
                    i % 3, tbl[i].special, tbl[i].s, tbl[i].res);

        // Timeout: core never answers; valid/err at T+66, late strobe ignored
        @(negedge clk);
        bus.doSqrt_i = 1'b1;
        bus.op_i     = 16'h4080;
        @(negedge clk);                         // cycle T+1
        bus.doSqrt_i = 1'b0;
        early = 0;
        for (int c = 1; c < TO + 2; c++) begin
            if (bus.valid_o) early++;
            @(negedge clk);
        end                                     // now cycle T+66
        check("timeout/no_early_valid", early, 0);
        check("timeout/valid", bus.valid_o, 1);
        check("timeout/err", bus.err_o, 1);
        check("timeout/result", bus.result_o, QNAN);
        @(negedge clk);
        check("timeout/valid_one_cycle", bus.valid_o | bus.err_o, 0);
        check("timeout/ready", bus.ready_o, 1);
        @(negedge clk);
        @(negedge clk);
        bus.core_valid_i  = 1'b1;
        bus.core_result_i = 16'h2000;
        @(negedge clk);
        bus.core_valid_i  = 1'b0;
        stray = 0;
        repeat (4) begin
            if (bus.valid_o | bus.err_o) stray++;
            @(negedge clk);
        end
        check("timeout/late_core_valid_ignored", stray, 0);

        // Reset in WAIT: back to IDLE next edge, later core strobe ignored
        bus.doInvSqrt_i = 1'b1;
        bus.op_i        = 16'h4080;
        @(negedge clk);
        bus.doInvSqrt_i = 1'b0;
        repeat (3) @(negedge clk);
        check("rstwait/busy", bus.ready_o, 0);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("rstwait/ready", bus.ready_o, 1);
        check("rstwait/valid", bus.valid_o, 0);
        check("rstwait/core_s", bus.core_s_o, 0);
        bus.core_valid_i  = 1'b1;
        bus.core_result_i = 16'h8000;
        @(negedge clk);
        bus.core_valid_i  = 1'b0;
        stray = 0;
        repeat (3) begin
            if (bus.valid_o) stray++;
            @(negedge clk);
        end
        check("rstwait/core_valid_ignored", stray, 0);
        check("rstwait/ready_after", bus.ready_o, 1);

        // Request while busy is dropped
        bus.doSqrt_i = 1'b1;
        bus.op_i     = 16'h4080;
        @(negedge clk);                         // T+1
        bus.doSqrt_i = 1'b0;
        @(negedge clk);                         // T+2, waiting
        bus.doInvSqrt_i = 1'b1;
        bus.op_i        = 16'h4000;
        @(negedge clk);
        bus.doInvSqrt_i = 1'b0;
        check("busy/no_new_cmd", {bus.core_doSqrt_o, bus.core_doInvSqrt_o}, 2'b00);
        check("busy/core_s_kept", bus.core_s_o, 8'h40);
        bus.core_valid_i  = 1'b1;
        bus.core_result_i = 16'h2000;
        @(negedge clk);
        bus.core_valid_i  = 1'b0;
        check("busy/result", bus.result_o, 16'h4000);
        check("busy/valid", bus.valid_o, 1);
        stray = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.valid_o | bus.core_doSqrt_o | bus.core_doInvSqrt_o) stray++;
        end
        check("busy/request_not_queued", stray, 0);

        // Randomized requests against the reference model
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 9) == 0) op = 16'($urandom);
            else op = {1'b0, 8'($urandom_range(1, 254)), 7'($urandom)};
            ds = 1'($urandom_range(0, 1));
            di = ds ? 1'($urandom_range(0, 1)) : 1'b1;
            if ($urandom_range(0, 7) == 0) cr = 16'($urandom_range(0, 16'h1FFF));
            else cr = 16'($urandom_range(16'h2000, 16'hFFFF));
            sp = ref_special(op, !ds);
            if (sp >= 0) begin
                run_txn("rand_special", ds, di, op, cr, 0, 1'b1, 8'h00, 16'(sp));
            end else begin
                ref_sig(op, s, k);
                res = ref_norm(cr, k, !ds);
                run_txn("rand_normal", ds, di, op, cr, $urandom_range(0, 5), 1'b0, s, res);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
